// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITER  = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple adder with carry-in (Pin) and carry-out (Pout).
module fulladder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Pin,
  output logic [31:0] S,
  output logic        Pout
);

  assign {Pout, S} = {1'b0, A} + {1'b0, B} + {32'h0, Pin};

endmodule

// File: rtl/seq_multiplier32.sv
// Unsigned 32x32->64 shift-and-add multiplier: one fulladder32, 32 iterations, start/busy/valid.
// Optional MUL_ZERO_SKIP_EN: a zero operand completes straight to DONE without iterating.
module seq_multiplier32
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        valid,
  output logic [63:0] P
);

  if ((WIDTH != 32) || ((2 ** CNT_W) <= WIDTH)) begin : g_bad_param
    $error("seq_multiplier32: WIDTH must be 32 and CNT_W must hold WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

  state_t           state;
  logic [31:0]      mcand;
  // The 65-bit accumulator's top bit is always zero between iterations, so only 64 bits are kept.
  logic [63:0]      acc;
  logic [CNT_W-1:0] cnt;

  logic [31:0] add_b;
  logic [31:0] sum;
  logic        cout;
  logic [63:0] next_acc;
  logic        zero_skip;

  // Addend selection: multiplicand when the current multiplier bit is set.
  always_comb begin
    add_b = 32'h0;
    if (acc[0]) begin
      add_b = mcand;
    end else begin
      add_b = 32'h0;
    end
  end

  fulladder32 u_adder (
    .A    (acc[63:32]),
    .B    (add_b),
    .Pin  (1'b0),
    .S    (sum),
    .Pout (cout)
  );

  assign next_acc = {cout, sum, acc[31:1]};

  // Zero-operand shortcut decision on the accepting edge.
  always_comb begin
    zero_skip = 1'b0;
`ifdef MUL_ZERO_SKIP_EN
    zero_skip = (A == 32'h0) || (B == 32'h0);
`else
    zero_skip = 1'b0;
`endif
  end

  // Control FSM, shift register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      P     <= 64'h0;
      cnt   <= '0;
      mcand <= 32'h0;
      acc   <= 64'h0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= '0;
            if (zero_skip) begin
              state <= DONE;
              busy  <= 1'b0;
              valid <= 1'b1;
              P     <= 64'h0;
              mcand <= 32'h0;
              acc   <= 64'h0;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
              valid <= 1'b0;
              mcand <= A;
              acc   <= {32'h0, B};
            end
          end
        end
        BUSY: begin
          acc <= next_acc;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
            P     <= next_acc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier32.sv
// Randomized self-checking bench for seq_multiplier32 against a plain-arithmetic product model.
module tb_seq_multiplier32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        valid;
  logic [63:0] P;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .valid (valid),
    .P     (P)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'h0, a};
    wb = {32'h0, b};
    return wa * wb;
  endfunction

  // Edges from the accepting edge (inclusive) until valid shows up.
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if ((a == 32'h0) || (b == 32'h0)) return 1;
`endif
    return 33;
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic pulse_busy);
    int n;
    int lat;
    n = 1;
    lat = exp_lat(a, b);
    check({tag, "_busy_acc"}, {63'h0, busy}, (lat == 33) ? 64'h1 : 64'h0);
    if (lat == 33) check({tag, "_valid_acc"}, {63'h0, valid}, 64'h0);
    while (!valid && n < 40) begin
      if (pulse_busy && n == 5) begin
        start = 1'b1;
        A = 32'd7;
        B = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (!valid && n <= 32) check({tag, "_busy_run"}, {63'h0, busy}, 64'h1);
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_P"}, P, ref_mul(a, b));
    check({tag, "_busy_done"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] prev;
    rst = 1'b1;
    start = 1'b0;
    A = 32'h0;
    B = 32'h0;
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_valid", {63'h0, valid}, 64'h0);
    check("rst_P", P, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    launch(32'd3, 32'd5);
    finish_op("basic", 32'd3, 32'd5, 1'b0);
    check("basic_const", P, 64'd15);
    repeat (3) @(negedge clk);
    check("hold_P", P, 64'd15);
    check("hold_valid", {63'h0, valid}, 64'h1);

    launch(32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("max_const", P, 64'hFFFFFFFE_00000001);

    launch(32'd2, 32'd3);
    finish_op("ignored", 32'd2, 32'd3, 1'b1);
    check("ignored_const", P, 64'd6);
    @(negedge clk);
    check("ignored_stays", {63'h0, valid}, 64'h1);

    launch(32'hABCD, 32'h1234);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_valid", {63'h0, valid}, 64'h0);
    check("midrst_P", P, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    launch(32'd100, 32'd100);
    finish_op("after_rst", 32'd100, 32'd100, 1'b0);
    check("after_rst_const", P, 64'd10000);

    prev = P;
    launch(32'h12345678, 32'h9ABCDEF0);
    check("b2b_P_held", P, prev);
    finish_op("b2b", 32'h12345678, 32'h9ABCDEF0, 1'b0);
    check("b2b_const", P, 64'h0B00EA4E_242D2080);

    launch(32'h0, 32'hDEAD);
    finish_op("zeroA", 32'h0, 32'hDEAD, 1'b0);
    launch(32'h1234, 32'h0);
    finish_op("zeroB", 32'h1234, 32'h0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(0, 15));
      if (i % 4 == 1) ra = 32'hFFFF0000 | 32'($urandom_range(0, 255));
      launch(ra, rb);
      finish_op($sformatf("rand%0d", i), ra, rb, (i % 2) == 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
